// File: rtl/clk_div_gen_if.sv
// Reload port of the clock-divider timebase: one shared valid/ready slot
// carrying the target channel, new period and new high time.
interface clk_div_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             load_valid;
    logic             load_ready;
    logic [CH_W-1:0]  load_ch;
    logic [DIV_W-1:0] load_div;
    logic [DIV_W-1:0] load_high;

    modport master (
        output load_valid,
        output load_ch,
        output load_div,
        output load_high,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_ch,
        input  load_div,
        input  load_high,
        output load_ready
    );
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider / timebase with registered divided clocks, per-period
// ticks and glitch-free runtime reload. Optional SYNC restart input: `CLK_GEN_SYNC_EN.
module clk_div_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
`ifdef CLK_GEN_SYNC_EN
    input  logic              sync,
`endif
    clk_div_gen_if.slave      ld,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] RST_HIGH = DIV_W'(DEFAULT_DIV / 2);

    logic [DIV_W-1:0] cnt_q    [NUM_CH];
    logic [DIV_W-1:0] div_q    [NUM_CH];
    logic [DIV_W-1:0] high_q   [NUM_CH];
    logic [DIV_W-1:0] cnt_nxt  [NUM_CH];
    logic [DIV_W-1:0] div_nxt  [NUM_CH];
    logic [DIV_W-1:0] high_nxt [NUM_CH];
    logic [DIV_W-1:0] use_div  [NUM_CH];
    logic [DIV_W-1:0] use_high [NUM_CH];
    logic [NUM_CH-1:0] out_nxt;
    logic [NUM_CH-1:0] tick_nxt;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] take;

    logic             pend_valid;
    logic [CH_W-1:0]  pend_ch;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] pend_high;
    logic [DIV_W-1:0] new_div;
    logic [DIV_W-1:0] new_high;
    logic             accept;
    logic             sync_w;

`ifdef CLK_GEN_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    assign ld.load_ready = !pend_valid;

    // Out-of-range channel numbers are acknowledged but never occupy the slot.
    assign accept = ld.load_valid && ld.load_ready &&
                    ({1'b0, ld.load_ch} < (CH_W + 1)'(NUM_CH));

    always_comb begin
        new_div  = (pend_div < DIV_W'(2)) ? DIV_W'(2) : pend_div;
        new_high = (pend_high >= new_div) ? (new_div - DIV_W'(1)) : pend_high;
    end

    always_comb begin
        out_nxt  = '0;
        tick_nxt = '0;
        hit      = '0;
        take     = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            hit[ch]      = pend_valid && (pend_ch == CH_W'(ch));
            use_div[ch]  = hit[ch] ? new_div  : div_q[ch];
            use_high[ch] = hit[ch] ? new_high : high_q[ch];
            cnt_nxt[ch]  = cnt_q[ch];
            div_nxt[ch]  = div_q[ch];
            high_nxt[ch] = high_q[ch];
            if (!en[ch]) begin
                take[ch]    = hit[ch];
                cnt_nxt[ch] = use_div[ch] - DIV_W'(1);
            end else if (sync_w || (cnt_q[ch] == div_q[ch] - DIV_W'(1))) begin
                // New period boundary; div>=2 so cnt 0 is never the tick cycle.
                take[ch]    = hit[ch];
                cnt_nxt[ch] = '0;
                out_nxt[ch] = (use_high[ch] != '0);
            end else begin
                cnt_nxt[ch]  = cnt_q[ch] + DIV_W'(1);
                out_nxt[ch]  = (cnt_nxt[ch] < high_q[ch]);
                tick_nxt[ch] = (cnt_nxt[ch] == div_q[ch] - DIV_W'(1));
            end
            if (take[ch]) begin
                div_nxt[ch]  = use_div[ch];
                high_nxt[ch] = use_high[ch];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch]  <= RST_DIV - DIV_W'(1);
                div_q[ch]  <= RST_DIV;
                high_q[ch] <= RST_HIGH;
            end
            clk_out    <= '0;
            tick       <= '0;
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_div   <= '0;
            pend_high  <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch]  <= cnt_nxt[ch];
                div_q[ch]  <= div_nxt[ch];
                high_q[ch] <= high_nxt[ch];
            end
            clk_out <= out_nxt;
            tick    <= tick_nxt;
            // Acceptance needs an empty slot, so it can never coincide with an apply.
            if (accept) begin
                pend_valid <= 1'b1;
                pend_ch    <= ld.load_ch;
                pend_div   <= ld.load_div;
                pend_high  <= ld.load_high;
            end else if (|take) begin
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_gen.sv
// Randomised self-checking bench for clk_div_gen against a phase-position model;
// exercises the SYNC input when CLK_GEN_SYNC_EN is defined.
module tb_clk_div_gen;
    logic       clk;
    logic       rst;
    logic [3:0] en;
    logic       sync;
    logic [3:0] clk_out;
    logic [3:0] tick;

    clk_div_gen_if #(.NUM_CH(4), .DIV_W(16)) ld_if ();

    clk_div_gen #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
`ifdef CLK_GEN_SYNC_EN
        .sync    (sync),
`endif
        .ld      (ld_if),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: each channel is a position within its period (-1 = not running).
    int m_phase [4];
    int m_div   [4];
    int m_high  [4];
    bit m_pv;
    int m_pch, m_pdiv, m_phigh;
    logic [3:0] exp_out, exp_tick;
    bit exp_ready;
    logic [3:0] en_cur;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step_model(input bit r, input logic [3:0] e, input bit v, input int c,
                              input int d, input int h, input bit s);
        bit applied;
        int nd, nh;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_phase[i] = -1;
                m_div[i]   = 4;
                m_high[i]  = 2;
            end
            m_pv = 0; exp_out = '0; exp_tick = '0; exp_ready = 1;
            return;
        end
        applied = 0;
        nd = (m_pdiv < 2) ? 2 : m_pdiv;
        nh = (m_phigh >= nd) ? nd - 1 : m_phigh;
        for (int i = 0; i < 4; i++) begin
            bit here;
            here = m_pv && (m_pch == i);
            if (!e[i]) begin
                if (here) begin m_div[i] = nd; m_high[i] = nh; applied = 1; end
                m_phase[i] = -1;
            end else if (s || m_phase[i] < 0 || m_phase[i] == m_div[i] - 1) begin
                if (here) begin m_div[i] = nd; m_high[i] = nh; applied = 1; end
                m_phase[i] = 0;
            end else begin
                m_phase[i] = m_phase[i] + 1;
            end
            exp_out[i]  = (m_phase[i] >= 0) && (m_phase[i] < m_high[i]);
            exp_tick[i] = (m_phase[i] == m_div[i] - 1);
        end
        if (!m_pv && v) begin
            m_pv = 1; m_pch = c; m_pdiv = d; m_phigh = h;
        end else if (applied) begin
            m_pv = 0;
        end
        exp_ready = !m_pv;
    endtask

    task automatic applyStimulus(input bit r, input logic [3:0] e, input bit v, input int c,
                                 input int d, input int h, input bit s);
        bit s_eff;
        s_eff = s;
`ifndef CLK_GEN_SYNC_EN
        s_eff = 1'b0;
`endif
        rst = r; en = e; sync = s_eff;
        ld_if.load_valid = v;
        ld_if.load_ch    = 2'(c);
        ld_if.load_div   = 16'(d);
        ld_if.load_high  = 16'(h);
        step_model(r, e, v, c, d, h, s_eff);
        @(posedge clk);
        @(negedge clk);
        checkOutput("clk_out", 32'(clk_out), 32'(exp_out));
        checkOutput("tick", 32'(tick), 32'(exp_tick));
        checkOutput("load_ready", 32'(ld_if.load_ready), 32'(exp_ready));
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, en_cur, 0, 0, 0, 0, 0);
    endtask

    task automatic do_load(input int c, input int d, input int h);
        for (int k = 0; k < 64 && m_pv; k++) applyStimulus(0, en_cur, 0, 0, 0, 0, 0);
        applyStimulus(0, en_cur, 1, c, d, h, 0);
    endtask

    initial begin
        en_cur = '0;
        applyStimulus(1, '0, 0, 0, 0, 0, 0);
        applyStimulus(1, '0, 0, 0, 0, 0, 0);
        checkOutput("reset_out", 32'(clk_out), 32'h0);
        checkOutput("reset_ready", 32'(ld_if.load_ready), 32'h1);

        // Default period 4: 1,1,0,0 with the tick on the second low cycle.
        en_cur = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, en_cur, 0, 0, 0, 0, 0);
            checkOutput("ch0_pattern", 32'(clk_out[0]), 32'((i % 4) < 2));
            checkOutput("ch0_tick", 32'(tick[0]), 32'((i % 4) == 3));
        end

        en_cur = 4'b0111;
        idle_cycles(2);
        do_load(1, 5, 1);
        idle_cycles(14);
        do_load(2, 1, 7);
        idle_cycles(8);
        do_load(3, 3, 0);
        idle_cycles(4);
        en_cur = 4'b1111;
        idle_cycles(10);

        // Drop ch2 while its output is high, then re-enable.
        for (int k = 0; k < 8 && !clk_out[2]; k++) idle_cycles(1);
        en_cur[2] = 1'b0;
        idle_cycles(1);
        checkOutput("ch2_idle_low", 32'(clk_out[2]), 32'h0);
        idle_cycles(2);
        en_cur[2] = 1'b1;
        idle_cycles(1);
        checkOutput("ch2_restart_high", 32'(clk_out[2]), 32'h1);
        idle_cycles(4);

        // Reset while a load is still waiting for its wrap.
        do_load(3, 9, 4);
        applyStimulus(1, en_cur, 0, 0, 0, 0, 0);
        checkOutput("rst_pending_ready", 32'(ld_if.load_ready), 32'h1);
        idle_cycles(12);

`ifdef CLK_GEN_SYNC_EN
        en_cur = 4'b0011;
        do_load(1, 6, 3);
        idle_cycles(9);
        applyStimulus(0, en_cur, 0, 0, 0, 0, 1);
        checkOutput("sync_align", 32'(clk_out[1:0]), 32'h3);
        idle_cycles(11);
        checkOutput("sync_tick12", 32'(tick[1:0]), 32'h3);
`endif

        for (int i = 0; i < 3000; i++) begin
            bit r, v, s;
            if ($urandom_range(0, 15) == 0) en_cur[$urandom_range(0, 3)] ^= 1'b1;
            r = ($urandom_range(0, 399) == 0);
            v = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 39) == 0);
            applyStimulus(r, en_cur, v, $urandom_range(0, 3), $urandom_range(0, 9),
                          $urandom_range(0, 11), s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
